// File: rtl/io_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_irq_pkg
// Description : Shared types, default widths and width helper for io_irq_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package io_irq_pkg;

    localparam int c_DATA_W_DEF = 16;
    localparam int c_N_IN_DEF   = 2;
    localparam int c_N_IRQ_DEF  = 4;
    localparam int c_SYNC_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    // Index width for a selector over `value` items, never narrower than 1 bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Multi-flop synchroniser for one async interrupt line plus a
//               history flop producing a single-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge
    import io_irq_pkg::*;
#(
    parameter int SYNC_STAGES = c_SYNC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/io_irq_unit.sv
`default_nettype none
// ============================================================================
// Module      : io_irq_unit
// Description : Input/output port registers and a maskable, lowest-index-first
//               interrupt controller with a request/ack/gap handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module io_irq_unit
    import io_irq_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W_DEF,
    parameter int N_IN        = c_N_IN_DEF,
    parameter int N_IRQ       = c_N_IRQ_DEF,
    parameter int SYNC_STAGES = c_SYNC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN*DATA_W-1:0]   in_port,
    input  logic [N_IRQ-1:0]         irq_in,
    input  logic                     rd_en,
    input  logic [clog2(N_IN)-1:0]   rd_sel,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        out_port,
    input  logic                     mask_we,
    input  logic [N_IRQ-1:0]         mask_wdata,
    output logic                     irq_req,
    output logic [clog2(N_IRQ)-1:0]  irq_vec,
    input  logic                     irq_ack,
    output logic [N_IRQ-1:0]         irq_pending
);

    localparam int c_SEL_W = clog2(N_IN);
    localparam int c_VEC_W = clog2(N_IRQ);

    irq_state_e           r_state;
    irq_state_e           w_state_nxt;
    logic [DATA_W-1:0]    r_rd_data;
    logic [DATA_W-1:0]    r_out_port;
    logic [N_IRQ-1:0]     r_mask;
    logic [N_IRQ-1:0]     r_pending;
    logic [c_VEC_W-1:0]   r_irq_vec;
    logic [N_IRQ-1:0]     w_rise;
    logic [N_IRQ-1:0]     w_eligible;
    logic [N_IRQ-1:0]     w_clr;
    logic [c_VEC_W-1:0]   w_prio_idx;
    logic                 w_any;
    logic                 w_load_vec;
    logic                 w_ack_take;
    logic [DATA_W-1:0]    w_rd_val;

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .reset     (reset),
            .irq_async (irq_in[gi]),
            .rise      (w_rise[gi])
        );
    end

    // Unmatched selector values (rd_sel >= N_IN) fall through to zero.
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (rd_sel == c_SEL_W'(k)) begin
                w_rd_val = in_port[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_out_port <= '0;
        end else begin
            if (rd_en) begin
                r_rd_data <= w_rd_val;
            end
            if (wr_en) begin
                r_out_port <= wr_data;
            end
        end
    end

    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;

    // Scan downwards so the lowest eligible index wins.
    always_comb begin
        w_prio_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_prio_idx = c_VEC_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_vec  = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = REQ;
                    w_load_vec  = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    w_state_nxt = GAP;
                    w_ack_take  = 1'b1;
                end
            end
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_clr            = '0;
        w_clr[r_irq_vec] = w_ack_take;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_irq_vec <= '0;
            r_mask    <= '1;
            r_pending <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_vec) begin
                r_irq_vec <= w_prio_idx;
            end
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            // Clear before set so a fresh edge on the acked line survives.
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    assign rd_data     = r_rd_data;
    assign out_port    = r_out_port;
    assign irq_req     = (r_state == REQ);
    assign irq_vec     = r_irq_vec;
    assign irq_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_io_irq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_irq_unit
// Description : Scoreboard bench for io_irq_unit: directed scenarios followed
//               by random traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_irq_unit;

    localparam int DATA_W      = 16;
    localparam int N_IN        = 2;
    localparam int N_IRQ       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int SEL_W       = 1;
    localparam int VEC_W       = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_IN*DATA_W-1:0] in_port;
    logic [N_IRQ-1:0]       irq_in;
    logic                   rd_en;
    logic [SEL_W-1:0]       rd_sel;
    logic [DATA_W-1:0]      rd_data;
    logic                   wr_en;
    logic [DATA_W-1:0]      wr_data;
    logic [DATA_W-1:0]      out_port;
    logic                   mask_we;
    logic [N_IRQ-1:0]       mask_wdata;
    logic                   irq_req;
    logic [VEC_W-1:0]       irq_vec;
    logic                   irq_ack;
    logic [N_IRQ-1:0]       irq_pending;

    always #5 clk = ~clk;

    io_irq_unit #(
        .DATA_W      (DATA_W),
        .N_IN        (N_IN),
        .N_IRQ       (N_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_port     (in_port),
        .irq_in      (irq_in),
        .rd_en       (rd_en),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .out_port    (out_port),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .irq_req     (irq_req),
        .irq_vec     (irq_vec),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending)
    );

    typedef struct {
        logic              req;
        logic [VEC_W-1:0]  vec;
        logic [N_IRQ-1:0]  pend;
        logic [DATA_W-1:0] outp;
        logic [DATA_W-1:0] rdd;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: raw samples of irq_in per edge, newest first.
    logic [N_IRQ-1:0]  m_samp[$];
    logic [N_IRQ-1:0]  m_pend;
    logic [N_IRQ-1:0]  m_mask;
    bit                m_req;
    bit                m_gap;
    int                m_vec;
    logic [DATA_W-1:0] m_out;
    logic [DATA_W-1:0] m_rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_samp.delete();
        repeat (SYNC_STAGES + 2) m_samp.push_front('0);
        m_pend = '0;
        m_mask = '1;
        m_req  = 1'b0;
        m_gap  = 1'b0;
        m_vec  = 0;
        m_out  = '0;
        m_rd   = '0;
    endtask

    // An edge becomes pending SYNC_STAGES clocks after it was first sampled.
    task automatic model_edge();
        logic [N_IRQ-1:0] rise;
        logic [N_IRQ-1:0] elig;
        if (!reset) begin
            model_reset();
            return;
        end
        m_samp.push_front(irq_in);
        void'(m_samp.pop_back());
        rise = m_samp[SYNC_STAGES] & ~m_samp[SYNC_STAGES+1];
        elig = m_pend & m_mask;
        if (m_req && irq_ack) m_pend[m_vec] = 1'b0;
        m_pend = m_pend | rise;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_req) begin
            if (irq_ack) begin
                m_req = 1'b0;
                m_gap = 1'b1;
            end
        end else if (elig != 0) begin
            m_req = 1'b1;
            for (int i = N_IRQ - 1; i >= 0; i--) if (elig[i]) m_vec = i;
        end
        if (mask_we) m_mask = mask_wdata;
        if (wr_en)   m_out  = wr_data;
        if (rd_en)   m_rd   = (rd_sel < N_IN) ? in_port[rd_sel*DATA_W +: DATA_W] : '0;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.req  = m_req;
        e.vec  = m_vec[VEC_W-1:0];
        e.pend = m_pend;
        e.outp = m_out;
        e.rdd  = m_rd;
        sbq.push_back(e);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!irq_req && n < 20) begin
            step();
            n++;
        end
        if (!irq_req) check("req_timeout", irq_req, 1);
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        check("arst_req",  irq_req, 0);
        check("arst_vec",  irq_vec, 0);
        check("arst_pend", irq_pending, 0);
        check("arst_out",  out_port, 0);
        check("arst_rd",   rd_data, 0);
        model_reset();
        sbq.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_req",  irq_req, e.req);
                check("sb_pend", irq_pending, e.pend);
                check("sb_out",  out_port, e.outp);
                check("sb_rd",   rd_data, e.rdd);
                if (e.req) check("sb_vec", irq_vec, e.vec);
            end
        end
    end

    initial begin : stim
        int n;
        reset = 1'b0; in_port = '0; irq_in = '0; rd_en = 1'b0; rd_sel = '0;
        wr_en = 1'b0; wr_data = '0; mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0;
        model_reset();
        repeat (2) step();
        check("rst_rd",   rd_data, 0);
        check("rst_out",  out_port, 0);
        check("rst_req",  irq_req, 0);
        check("rst_vec",  irq_vec, 0);
        check("rst_pend", irq_pending, 0);
        reset = 1'b1;
        step();

        // Port I/O
        in_port = {16'h0019, 16'h0005};
        rd_en = 1'b1; rd_sel = 1'b1; step();
        check("io_rd1", rd_data, 16'h0019);
        rd_sel = 1'b0; step();
        check("io_rd0", rd_data, 16'h0005);
        rd_en = 1'b0; wr_en = 1'b1; wr_data = 16'hF320; in_port = '1; step();
        check("io_wr", out_port, 16'hF320);
        wr_en = 1'b0; wr_data = 16'h1234; step();
        check("io_wr_hold", out_port, 16'hF320);
        check("io_rd_hold", rd_data, 16'h0005);

        // Latency: line 2 sampled high at edge t0
        irq_in[2] = 1'b1; step();
        wait_req(n);
        check("lat_edges", n, 3);
        check("lat_vec", irq_vec, 2);
        step(); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check("lat_ack_req", irq_req, 0);
        check("lat_ack_pend2", irq_pending[2], 0);
        repeat (4) step();
        check("lat_level_no_retrig", irq_req, 0);
        irq_in = '0; step();

        // Priority
        irq_in = 4'b1010;
        wait_req(n);
        check("prio_first", irq_vec, 1);
        irq_in = 4'b1011;
        repeat (4) step();
        check("prio_hold_req", irq_req, 1);
        check("prio_hold_vec", irq_vec, 1);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check("prio_gap", irq_req, 0);
        step();
        check("prio_idle", irq_req, 0);
        step();
        check("prio_second_req", irq_req, 1);
        check("prio_second_vec", irq_vec, 0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        step(); step();
        check("prio_third_vec", irq_vec, 3);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_in = '0; repeat (3) step();

        // Mask
        mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
        irq_in[0] = 1'b1; step(); irq_in[0] = 1'b0;
        repeat (5) step();
        check("mask_pend0", irq_pending[0], 1);
        check("mask_no_req", irq_req, 0);
        mask_we = 1'b1; mask_wdata = 4'hF; step(); mask_we = 1'b0;
        step();
        check("mask_req", irq_req, 1);
        check("mask_vec", irq_vec, 0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        repeat (2) step();

        // Set wins over ack-clear on the same line
        irq_in[2] = 1'b1; step(); irq_in[2] = 1'b0;
        wait_req(n);
        check("sw_vec", irq_vec, 2);
        irq_in[2] = 1'b1; step(); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        check("sw_pend2", irq_pending[2], 1);
        check("sw_gap", irq_req, 0);
        step(); step();
        check("sw_rereq", irq_req, 1);
        check("sw_revec", irq_vec, 2);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_in = '0; repeat (3) step();

        // Asynchronous reset in REQ with two pending lines
        irq_in = 4'b1010;
        wait_req(n);
        check("pre_rst_pend", irq_pending, 4'b1010);
        async_reset();
        irq_in = '0;
        step(); step();
        reset = 1'b1;
        step();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            in_port    = {16'($urandom), 16'($urandom)};
            rd_en      = ($urandom_range(0, 1) == 1);
            rd_sel     = SEL_W'($urandom_range(0, 1));
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_data    = 16'($urandom);
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = 4'($urandom);
            irq_ack    = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N_IRQ; i++)
                if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
                step();
                reset = 1'b1;
            end
            step();
        end

        irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
